// File: rtl/flash_loader.sv
// Boot-time copier: reads TransferByteCount bytes from SPI flash (READ 0x03)
// and writes them little-endian packed as 32-bit words through the ramio port.
module flash_loader #(
  parameter int unsigned StartupWaitCycles = 0,
  parameter int unsigned TransferByteCount = 2048,
  parameter logic [23:0] FlashReadAddress  = 24'h000000,
  parameter logic [31:0] RamStartAddress   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        busy,
  output logic        done,
  output logic        flash_clk,
  input  logic        flash_miso,
  output logic        flash_mosi,
  output logic        flash_cs_n,
  output logic        ramio_enable,
  output logic [1:0]  ramio_write_type,
  output logic [2:0]  ramio_read_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy
);

  localparam int unsigned ByteCntW = $clog2(TransferByteCount) + 1;
  localparam int unsigned WaitCntW = (StartupWaitCycles > 0) ? $clog2(StartupWaitCycles + 1) : 1;
  localparam logic [31:0] Cmd = {8'h03, FlashReadAddress};
  localparam logic [ByteCntW-1:0] ByteTotal = ByteCntW'(TransferByteCount);
  localparam logic [WaitCntW-1:0] WaitTotal = WaitCntW'(StartupWaitCycles);

  typedef enum logic [2:0] {
    StStartup, StCommand, StReadByte, StWriteIssue, StWriteWait, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
  logic                phase_q, phase_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [31:0]         tx_q, tx_d;
  logic [6:0]          rx_q, rx_d;
  logic [31:0]         word_q, word_d;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_idx_q, word_idx_d;
  logic                gap_q, gap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                en_q, en_d;
  logic [1:0]          wtype_q, wtype_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StStartup;
      wait_cnt_q <= '0;
      phase_q    <= 1'b0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      gap_q      <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      en_q       <= 1'b0;
      wtype_q    <= 2'd0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      en_q       <= en_d;
      wtype_q    <= wtype_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Next-state and output logic; each SPI bit is a low phase then a high phase
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    done_d     = done_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    en_d       = 1'b0;
    wtype_d    = 2'd0;
    addr_d     = addr_q;
    data_d     = data_q;
    unique case (state_q)
      StStartup: begin
        if (wait_cnt_q == WaitTotal) begin
          cs_n_d    = 1'b0;
          mosi_d    = Cmd[31];
          tx_d      = {Cmd[30:0], 1'b0};
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = StCommand;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitCntW'(1);
        end
      end
      StCommand: begin
        sck_d   = ~phase_q;
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bit_cnt_q == 5'd31) begin
            mosi_d    = 1'b0;
            bit_cnt_d = '0;
            state_d   = StReadByte;
          end else begin
            mosi_d    = tx_q[31];
            tx_d      = {tx_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      StReadByte: begin
        sck_d   = ~phase_q;
        phase_d = ~phase_q;
        if (phase_q) begin
          rx_d = {rx_q[5:0], flash_miso};
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = {rx_q, flash_miso};
            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
            if (byte_cnt_q[1:0] == 2'd3) state_d = StWriteIssue;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      StWriteIssue: begin
        if (!ramio_busy) begin
          en_d       = 1'b1;
          wtype_d    = 2'd3;
          addr_d     = RamStartAddress + (word_idx_q << 2);
          data_d     = word_q;
          word_idx_d = word_idx_q + 32'd1;
          gap_d      = 1'b1;
          state_d    = StWriteWait;
        end
      end
      StWriteWait: begin
        // First cycle ignores ramio_busy: ramio has not yet reacted to the strobe
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (!ramio_busy) begin
          if (byte_cnt_q == ByteTotal) begin
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StReadByte;
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StStartup;
      end
    endcase
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign flash_clk        = sck_q;
  assign flash_mosi       = mosi_q;
  assign flash_cs_n       = cs_n_q;
  assign ramio_enable     = en_q;
  assign ramio_write_type = wtype_q;
  assign ramio_read_type  = 3'd0;
  assign ramio_address    = addr_q;
  assign ramio_data_in    = data_q;

endmodule
